// File: rtl/delay_tap_reader.sv
// Echo tap fetcher: reads the sample lying `delay` behind the write pointer
// through a req/gnt/rvalid arbiter port, with timeout recovery and a one-deep pending slot.
module delay_tap_reader #(
    parameter int SIG_BITS = 16,
    parameter int DLY_B    = 14,
    parameter int TIMEOUT  = 64
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                wr_strobe_i,
    input  logic [DLY_B-1:0]    wr_ptr_i,
    input  logic [DLY_B-1:0]    delay_i,
    output logic                mem_req_o,
    output logic [DLY_B-1:0]    mem_addr_o,
    input  logic                mem_gnt_i,
    input  logic                mem_rvalid_i,
    input  logic [SIG_BITS-1:0] mem_rdata_i,
    output logic [SIG_BITS-1:0] tap_o,
    output logic                tap_valid_o,
    output logic                tap_underrun_o
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_OUT  = 2'd3
    } state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                pend_q;
    logic [DLY_B-1:0]    pend_addr_q;
    logic                stale_q;
    logic                mem_req_q;
    logic [DLY_B-1:0]    mem_addr_q;
    logic [SIG_BITS-1:0] tap_q;
    logic                tap_valid_q;
    logic                tap_underrun_q;

    logic [DLY_B-1:0]    eff_d;
    logic [DLY_B-1:0]    addr_d;
    logic                timeout_d;

    // A zero delay would read the slot being written, so it is clamped to one.
    always_comb begin
        eff_d     = (delay_i == '0) ? DLY_B'(1) : delay_i;
        addr_d    = wr_ptr_i - eff_d;
        timeout_d = (cnt_q == CNT_W'(TIMEOUT - 1));
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            pend_q         <= 1'b0;
            pend_addr_q    <= '0;
            stale_q        <= 1'b0;
            mem_req_q      <= 1'b0;
            mem_addr_q     <= '0;
            tap_q          <= '0;
            tap_valid_q    <= 1'b0;
            tap_underrun_q <= 1'b0;
        end else begin
            tap_valid_q    <= 1'b0;
            tap_underrun_q <= 1'b0;

            // A late response from an aborted fetch is swallowed wherever it lands.
            if (mem_rvalid_i && stale_q)
                stale_q <= 1'b0;

            if (wr_strobe_i && (state_q != ST_IDLE)) begin
                pend_q      <= 1'b1;
                pend_addr_q <= addr_d;
            end

            case (state_q)
                ST_IDLE: begin
                    if (wr_strobe_i) begin
                        mem_addr_q <= addr_d;
                        mem_req_q  <= 1'b1;
                        cnt_q      <= '0;
                        state_q    <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (mem_gnt_i) begin
                        mem_req_q <= 1'b0;
                        cnt_q     <= cnt_q + 1'b1;
                        state_q   <= ST_WAIT;
                    end else if (timeout_d) begin
                        mem_req_q      <= 1'b0;
                        tap_valid_q    <= 1'b1;
                        tap_underrun_q <= 1'b1;
                        state_q        <= ST_OUT;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (mem_rvalid_i && !stale_q) begin
                        tap_q       <= mem_rdata_i;
                        tap_valid_q <= 1'b1;
                        state_q     <= ST_OUT;
                    end else if (timeout_d) begin
                        stale_q        <= 1'b1;
                        tap_valid_q    <= 1'b1;
                        tap_underrun_q <= 1'b1;
                        state_q        <= ST_OUT;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_OUT: begin
                    // A strobe landing here either refills the pending slot or starts directly.
                    if (pend_q) begin
                        mem_addr_q <= pend_addr_q;
                        pend_q     <= wr_strobe_i;
                        mem_req_q  <= 1'b1;
                        cnt_q      <= '0;
                        state_q    <= ST_REQ;
                    end else if (wr_strobe_i) begin
                        mem_addr_q <= addr_d;
                        pend_q     <= 1'b0;
                        mem_req_q  <= 1'b1;
                        cnt_q      <= '0;
                        state_q    <= ST_REQ;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign mem_req_o      = mem_req_q;
    assign mem_addr_o     = mem_addr_q;
    assign tap_o          = tap_q;
    assign tap_valid_o    = tap_valid_q;
    assign tap_underrun_o = tap_underrun_q;

endmodule

// File: tb/tb_delay_tap_reader.sv
// Directed bench for delay_tap_reader: vector table for plain fetches plus
// hand-written sequences for timeout, stale response, pending strobes and reset.
module tb_delay_tap_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_strobe;
    logic [13:0] wr_ptr;
    logic [13:0] dly;
    logic        mem_req;
    logic [13:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [15:0] mem_rdata;
    logic [15:0] tap;
    logic        tap_valid;
    logic        tap_underrun;

    int checks = 0;
    int errors = 0;

    delay_tap_reader #(.SIG_BITS(16), .DLY_B(14), .TIMEOUT(64)) dut (
        .clk_i          (clk),
        .reset_i        (reset),
        .wr_strobe_i    (wr_strobe),
        .wr_ptr_i       (wr_ptr),
        .delay_i        (dly),
        .mem_req_o      (mem_req),
        .mem_addr_o     (mem_addr),
        .mem_gnt_i      (mem_gnt),
        .mem_rvalid_i   (mem_rvalid),
        .mem_rdata_i    (mem_rdata),
        .tap_o          (tap),
        .tap_valid_o    (tap_valid),
        .tap_underrun_o (tap_underrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [13:0] wr_ptr;
        logic [13:0] dly;
        logic [15:0] rdata;
        logic [13:0] exp_addr;
    } vec_t;

    vec_t vecs [5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Minimum-latency fetch: grant in cycle 1, rvalid in cycle 2, tap in cycle 3.
    task automatic run_fetch(input logic [13:0] p, input logic [13:0] d,
                             input logic [15:0] rd, input logic [13:0] ea, input int idx);
        wr_ptr = p; dly = d; wr_strobe = 1'b1;
        tick();
        wr_strobe = 1'b0;
        chk($sformatf("v%0d req_c1", idx), 32'(mem_req), 32'd1);
        chk($sformatf("v%0d addr", idx), 32'(mem_addr), 32'(ea));
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        chk($sformatf("v%0d req_c2", idx), 32'(mem_req), 32'd0);
        mem_rvalid = 1'b1; mem_rdata = rd;
        tick();
        mem_rvalid = 1'b0;
        chk($sformatf("v%0d valid_c3", idx), 32'(tap_valid), 32'd1);
        chk($sformatf("v%0d tap", idx), 32'(tap), 32'(rd));
        chk($sformatf("v%0d underrun", idx), 32'(tap_underrun), 32'd0);
        tick();
        chk($sformatf("v%0d valid_c4", idx), 32'(tap_valid), 32'd0);
        $display("vec %0d wr_ptr=%0d delay=%0d addr=%0d tap=0x%04h", idx, p, d, mem_addr, tap);
    endtask

    task automatic wait_valid(input int limit, output int n);
        n = 0;
        while (!tap_valid && n < limit) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n;
        vecs[0] = '{wr_ptr: 14'd100,   dly: 14'd40,    rdata: 16'h1234, exp_addr: 14'd60};
        vecs[1] = '{wr_ptr: 14'd2,     dly: 14'd5,     rdata: 16'h5555, exp_addr: 14'd16381};
        vecs[2] = '{wr_ptr: 14'd0,     dly: 14'd1,     rdata: 16'h8001, exp_addr: 14'd16383};
        vecs[3] = '{wr_ptr: 14'd16383, dly: 14'd16383, rdata: 16'h7FFF, exp_addr: 14'd0};
        vecs[4] = '{wr_ptr: 14'd7,     dly: 14'd0,     rdata: 16'h00AA, exp_addr: 14'd6};

        reset = 1'b1; wr_strobe = 1'b0; wr_ptr = '0; dly = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        tick(); tick();
        reset = 1'b0;
        chk("rst mem_req", 32'(mem_req), 32'd0);
        chk("rst mem_addr", 32'(mem_addr), 32'd0);
        chk("rst tap", 32'(tap), 32'd0);
        chk("rst tap_valid", 32'(tap_valid), 32'd0);
        chk("rst underrun", 32'(tap_underrun), 32'd0);
        $display("reset outputs checked");
        tick();

        for (int i = 0; i < 5; i++)
            run_fetch(vecs[i].wr_ptr, vecs[i].dly, vecs[i].rdata, vecs[i].exp_addr, i);

        // Grant withheld: abort TIMEOUT cycles after REQ entry, tap held.
        wr_ptr = 14'd50; dly = 14'd10; wr_strobe = 1'b1;
        tick();
        wr_strobe = 1'b0;
        chk("to_req addr", 32'(mem_addr), 32'd40);
        wait_valid(200, n);
        chk("to_req cycles", 32'(n), 32'd64);
        chk("to_req tap", 32'(tap), 32'h00AA);
        chk("to_req underrun", 32'(tap_underrun), 32'd1);
        chk("to_req req_low", 32'(mem_req), 32'd0);
        tick();
        chk("to_req idle valid", 32'(tap_valid), 32'd0);
        chk("to_req idle req", 32'(mem_req), 32'd0);
        $display("timeout in REQ after %0d cycles tap=0x%04h", n, tap);

        // Abort in WAIT, then stale rvalid lands in the next fetch's WAIT.
        wr_ptr = 14'd200; dly = 14'd100; wr_strobe = 1'b1;
        tick();
        wr_strobe = 1'b0; mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        wait_valid(200, n);
        chk("to_wait cycles", 32'(n), 32'd63);
        chk("to_wait underrun", 32'(tap_underrun), 32'd1);
        chk("to_wait tap", 32'(tap), 32'h00AA);
        tick();
        wr_ptr = 14'd300; dly = 14'd50; wr_strobe = 1'b1;
        tick();
        wr_strobe = 1'b0;
        chk("stale addr", 32'(mem_addr), 32'd250);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 16'hDEAD;
        tick();
        mem_rvalid = 1'b0;
        chk("stale discard valid", 32'(tap_valid), 32'd0);
        chk("stale discard tap", 32'(tap), 32'h00AA);
        tick();
        mem_rvalid = 1'b1; mem_rdata = 16'h0BEE;
        tick();
        mem_rvalid = 1'b0;
        chk("stale real valid", 32'(tap_valid), 32'd1);
        chk("stale real tap", 32'(tap), 32'h0BEE);
        chk("stale real underrun", 32'(tap_underrun), 32'd0);
        tick();
        $display("stale response test tap=0x%04h", tap);

        // Two strobes while busy collapse into one follow-up fetch.
        wr_ptr = 14'd20; dly = 14'd1; wr_strobe = 1'b1;
        tick();
        chk("pend first addr", 32'(mem_addr), 32'd19);
        wr_ptr = 14'd10; mem_gnt = 1'b1;
        tick();
        wr_ptr = 14'd11; mem_gnt = 1'b0;
        tick();
        wr_strobe = 1'b0; mem_rvalid = 1'b1; mem_rdata = 16'h1111;
        tick();
        mem_rvalid = 1'b0;
        chk("pend out valid", 32'(tap_valid), 32'd1);
        chk("pend out tap", 32'(tap), 32'h1111);
        tick();
        chk("pend re-req", 32'(mem_req), 32'd1);
        chk("pend addr", 32'(mem_addr), 32'd10);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 16'h2222;
        tick();
        mem_rvalid = 1'b0;
        chk("pend second tap", 32'(tap), 32'h2222);
        tick();
        chk("pend no third req", 32'(mem_req), 32'd0);
        tick();
        chk("pend idle req", 32'(mem_req), 32'd0);
        $display("pending strobe test tap=0x%04h", tap);

        // Reset while waiting for data.
        wr_ptr = 14'd500; dly = 14'd5; wr_strobe = 1'b1;
        tick();
        wr_strobe = 1'b0; mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst mem_req", 32'(mem_req), 32'd0);
        chk("midrst mem_addr", 32'(mem_addr), 32'd0);
        chk("midrst tap", 32'(tap), 32'd0);
        chk("midrst valid", 32'(tap_valid), 32'd0);
        chk("midrst underrun", 32'(tap_underrun), 32'd0);
        $display("mid-fetch reset checked");
        run_fetch(14'd1000, 14'd1000, 16'h4321, 14'd0, 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
